axi_pipe_cfg: RTL

Configurable AXI4 pipeline inserted between a slave port and a master port to break long timing paths. The number of register stages and the cut type are set independently for each of the five channels (AW, W, B, AR, R). Each stage is a spill register, a forward-only register or a backward-only skid buffer. The block also reports per-channel occupancy and a global idle flag, so power or clock-gating logic can tell when the pipe is drained.

---
 rtl/axi_pipe_pkg.sv | 45 ++++
 rtl/axi_pipe_chan.sv | 129 ++++++++++++
 rtl/axi_pipe_cfg.sv | 137 +++++++++++++
 3 files changed

// File: rtl/axi_pipe_pkg.sv
// Shared types and helpers for the configurable AXI pipeline.
// Default request/response structs carry 1-bit payloads.
package axi_pipe_pkg;

  typedef enum logic [1:0] {
    CutSpill,
    CutFwd,
    CutBwd
  } cut_mode_e;

  function automatic int unsigned occ_width(
    int unsigned max_cuts
  );
    return (max_cuts == 0) ? 1 : $clog2(2 * max_cuts + 1);
  endfunction

  function automatic int unsigned cut_max(
    int unsigned a,
    int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  typedef struct packed {
    logic aw;
    logic aw_valid;
    logic w;
    logic w_valid;
    logic b_ready;
    logic ar;
    logic ar_valid;
    logic r_ready;
  } axi_req_dflt_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    logic b;
    logic b_valid;
    logic ar_ready;
    logic r;
    logic r_valid;
  } axi_resp_dflt_t;

endpackage

// File: rtl/axi_pipe_chan.sv
// Generic valid/ready/data chain of identical cut stages.
// Reports the number of beats held across all its stages.
module axi_pipe_chan
  import axi_pipe_pkg::*;
#(
  parameter type         T    = logic,
  parameter int unsigned Cuts = 1,
  parameter cut_mode_e   Mode = CutSpill,
  parameter int unsigned OccW = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  T                data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output T                data_o,
  output logic [OccW-1:0] occ_o
);

  if (Cuts == 0) begin : g_wire
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign occ_o   = '0;
  end else begin : g_pipe
    logic            v   [Cuts+1];
    logic            r   [Cuts+1];
    T                d   [Cuts+1];
    logic [OccW-1:0] cnt [Cuts];

    assign v[0]    = valid_i;
    assign d[0]    = data_i;
    assign ready_o = r[0];
    assign valid_o = v[Cuts];
    assign data_o  = d[Cuts];
    assign r[Cuts] = ready_i;

    for (genvar i = 0; i < Cuts; i++) begin : g_stage
      if (Mode == CutSpill) begin : g_spill
        logic a_full, b_full, push, pop;
        T     a_data, b_data;

        assign r[i]   = ~b_full;
        assign v[i+1] = a_full;
        assign d[i+1] = a_data;
        assign push   = v[i] & ~b_full;
        assign pop    = a_full & r[i+1];
        assign cnt[i] = OccW'(a_full) + OccW'(b_full);

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
            a_data <= '0;
            b_data <= '0;
          end else if (pop) begin
            // B refills A first; push cannot coincide with B full
            if (b_full) begin
              a_data <= b_data;
              b_full <= 1'b0;
            end else if (push) begin
              a_data <= d[i];
            end else begin
              a_full <= 1'b0;
            end
          end else if (push) begin
            if (a_full) begin
              b_full <= 1'b1;
              b_data <= d[i];
            end else begin
              a_full <= 1'b1;
              a_data <= d[i];
            end
          end
        end
      end else if (Mode == CutFwd) begin : g_fwd
        logic full;
        T     data;

        assign r[i]   = ~full | r[i+1];
        assign v[i+1] = full;
        assign d[i+1] = data;
        assign cnt[i] = OccW'(full);

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            full <= 1'b0;
            data <= '0;
          end else if (v[i] && r[i]) begin
            full <= 1'b1;
            data <= d[i];
          end else if (r[i+1]) begin
            full <= 1'b0;
          end
        end
      end else begin : g_bwd
        logic full;
        T     data;

        assign r[i]   = ~full;
        assign v[i+1] = v[i] | full;
        assign d[i+1] = full ? data : d[i];
        assign cnt[i] = OccW'(full);

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            full <= 1'b0;
            data <= '0;
          end else if (full) begin
            if (r[i+1]) full <= 1'b0;
          end else if (v[i] && !r[i+1]) begin
            full <= 1'b1;
            data <= d[i];
          end
        end
      end
    end

    always_comb begin
      occ_o = '0;
      for (int i = 0; i < int'(Cuts); i++) begin
        occ_o = occ_o + cnt[i];
      end
    end
  end

endmodule

// File: rtl/axi_pipe_cfg.sv
// Per-channel configurable AXI4 register pipeline.
// B and R chains run master to slave; occupancy drives idle_o.
module axi_pipe_cfg
  import axi_pipe_pkg::*;
#(
  parameter int unsigned AwCuts     = 1,
  parameter int unsigned WCuts      = 1,
  parameter int unsigned BCuts      = 1,
  parameter int unsigned ArCuts     = 1,
  parameter int unsigned RCuts      = 1,
  parameter cut_mode_e   AwMode     = CutSpill,
  parameter cut_mode_e   WMode      = CutSpill,
  parameter cut_mode_e   BMode      = CutSpill,
  parameter cut_mode_e   ArMode     = CutSpill,
  parameter cut_mode_e   RMode      = CutSpill,
  parameter type         aw_chan_t  = logic,
  parameter type         w_chan_t   = logic,
  parameter type         b_chan_t   = logic,
  parameter type         ar_chan_t  = logic,
  parameter type         r_chan_t   = logic,
  parameter type         axi_req_t  = axi_req_dflt_t,
  parameter type         axi_resp_t = axi_resp_dflt_t,
  localparam int unsigned MaxCuts =
    cut_max(cut_max(cut_max(AwCuts, WCuts),
                    cut_max(BCuts, ArCuts)), RCuts),
  localparam int unsigned OccW = occ_width(MaxCuts)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  axi_req_t             slv_req_i,
  output axi_resp_t            slv_resp_o,
  output axi_req_t             mst_req_o,
  input  axi_resp_t            mst_resp_i,
  output logic [4:0][OccW-1:0] occ_o,
  output logic                 idle_o
);

  logic     aw_v, aw_r, w_v, w_r, ar_v, ar_r;
  logic     b_v, b_r, r_v, r_r;
  aw_chan_t aw_d;
  w_chan_t  w_d;
  b_chan_t  b_d;
  ar_chan_t ar_d;
  r_chan_t  r_d;

  axi_pipe_chan #(
    .T(aw_chan_t), .Cuts(AwCuts), .Mode(AwMode), .OccW(OccW)
  ) u_aw (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.aw_valid),
    .ready_o(aw_r),
    .data_i (slv_req_i.aw),
    .valid_o(aw_v),
    .ready_i(mst_resp_i.aw_ready),
    .data_o (aw_d),
    .occ_o  (occ_o[4])
  );

  axi_pipe_chan #(
    .T(w_chan_t), .Cuts(WCuts), .Mode(WMode), .OccW(OccW)
  ) u_w (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.w_valid),
    .ready_o(w_r),
    .data_i (slv_req_i.w),
    .valid_o(w_v),
    .ready_i(mst_resp_i.w_ready),
    .data_o (w_d),
    .occ_o  (occ_o[3])
  );

  axi_pipe_chan #(
    .T(b_chan_t), .Cuts(BCuts), .Mode(BMode), .OccW(OccW)
  ) u_b (
    .clk_i, .rst_ni,
    .valid_i(mst_resp_i.b_valid),
    .ready_o(b_r),
    .data_i (mst_resp_i.b),
    .valid_o(b_v),
    .ready_i(slv_req_i.b_ready),
    .data_o (b_d),
    .occ_o  (occ_o[2])
  );

  axi_pipe_chan #(
    .T(ar_chan_t), .Cuts(ArCuts), .Mode(ArMode), .OccW(OccW)
  ) u_ar (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.ar_valid),
    .ready_o(ar_r),
    .data_i (slv_req_i.ar),
    .valid_o(ar_v),
    .ready_i(mst_resp_i.ar_ready),
    .data_o (ar_d),
    .occ_o  (occ_o[1])
  );

  axi_pipe_chan #(
    .T(r_chan_t), .Cuts(RCuts), .Mode(RMode), .OccW(OccW)
  ) u_r (
    .clk_i, .rst_ni,
    .valid_i(mst_resp_i.r_valid),
    .ready_o(r_r),
    .data_i (mst_resp_i.r),
    .valid_o(r_v),
    .ready_i(slv_req_i.r_ready),
    .data_o (r_d),
    .occ_o  (occ_o[0])
  );

  // Fields not owned by a channel pass straight through
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = aw_v;
    mst_req_o.aw       = aw_d;
    mst_req_o.w_valid  = w_v;
    mst_req_o.w        = w_d;
    mst_req_o.ar_valid = ar_v;
    mst_req_o.ar       = ar_d;
    mst_req_o.b_ready  = b_r;
    mst_req_o.r_ready  = r_r;
  end

  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = aw_r;
    slv_resp_o.w_ready  = w_r;
    slv_resp_o.ar_ready = ar_r;
    slv_resp_o.b_valid  = b_v;
    slv_resp_o.b        = b_d;
    slv_resp_o.r_valid  = r_v;
    slv_resp_o.r        = r_d;
  end

  assign idle_o = (occ_o == '0);

endmodule
